fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller for the RISC-V core. Owns the architectural PC register and sequences fetch through a valid/ready instruction-memory port. Applies jump/branch redirects from execute and stalls from the hazard unit. Delivers each fetched instruction to decode over a valid/ready handshake, with exactly one memory request outstanding.

## Interface
- XLEN, 64: PC and address width.
- RESET_PC, 64'h0: PC loaded on reset.
- TRAP_VEC, 64'h100: redirect destination for misaligned targets (used only with PC_MISALIGN_TRAP_EN).
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset: asynchronous, active-low.
- stall  in  1  hazard unit: no new imem request while high.
- jump  in  1  execute: unconditional redirect.
- jump_target  in  XLEN  jump destination.
- branch_taken  in  1  execute: taken branch.
- branch_target  in  XLEN  branch destination.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address; equals the PC register.
- imem_rsp_valid  in  1  response strobe, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  32  presented instruction.
- flush  out  1  combinational: (jump | branch_taken), forced 0 while rst_n is low.
- misalign_exc  out  1  one-cycle pulse (macro only).
- exc_addr  out  XLEN  last offending target (macro only).

## Operation
- States:
  - IDLE: one cycle after reset.
  - FETCH: request issued when !stall.
  - WAIT_RSP: awaiting the response.
  - HOLD: instruction registered; if_valid=1.
  - DRAIN: discard one stale response.
- Redirect target selection: jump has priority over branch_taken.
- Normal transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH: imem_req_valid = !stall. On accept (valid & ready) -> WAIT_RSP.
  - WAIT_RSP: on imem_rsp_valid, capture data into if_instr and the PC into if_pc, then -> HOLD.
  - HOLD: on if_valid & if_ready, pc <= pc + 4 (modulo 2^XLEN, 64'hFFFF_FFFF_FFFF_FFFC wraps to 0) and -> FETCH.
- Redirect (jump or branch_taken high) has priority over every other event in every state. pc <= target. Then:
  - FETCH, not accepted this cycle -> FETCH; imem_req_addr shows the new target next cycle.
  - FETCH, accepted the same cycle -> DRAIN.
  - WAIT_RSP, no response this cycle -> DRAIN.
  - WAIT_RSP, response this cycle -> response discarded, -> FETCH.
  - HOLD -> FETCH; the held instruction is dropped (a same-cycle handoff is flushed via flush=1).
  - DRAIN: stays DRAIN, pc updated.
  - DRAIN with a response the same cycle -> response discarded, -> FETCH.
  - IDLE -> FETCH, pc = target.
- DRAIN: the first imem_rsp_valid is discarded; no if_valid is produced. Then -> FETCH.
- Stall:
  - Gates only new request issue in FETCH.
  - Does not drop an accepted request, a pending response or a held instruction.
  - imem_req_valid may fall while stall rises before acceptance (requests are not sticky).
- Reset mid-operation:
  - Abandons the outstanding request.
  - The first response after reset arrives in IDLE/FETCH and is ignored; responses are accepted only in WAIT_RSP/DRAIN.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, flush=0, misalign_exc=0, exc_addr=0.
- imem_req_valid is first high in the second cycle after rst_n deasserts (IDLE occupies one cycle).
- Latency from accept (cycle N) with response at cycle M>N: if_valid rises at M+1.
- Minimum 3 cycles per instruction with zero-wait memory and if_ready held high.
- Redirect at cycle N: imem_req_addr = target by N+1 if no request is outstanding.
- if_valid, if_pc and if_instr are stable while if_valid & !if_ready.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A redirect target with [1:0] != 0 loads pc <= TRAP_VEC.
  - misalign_exc pulses high the cycle after the redirect.
  - exc_addr <= offending target.
  - Aligned targets behave normally.
- PC_MISALIGN_TRAP_EN undefined:
  - misalign_exc and exc_addr ports are absent.
  - Targets load as {target[XLEN-1:2], 2'b00}.

## Structure
- Shared package riscv_fetch_pkg holds: state enum fetch_state_t, XLEN, INSTR_W=32, ILEN_BYTES=4.
- One sub-module, fetch_next_pc: combinational target select (jump > branch > pc+4), plus the alignment/trap substitution under the macro.
- State register and PC register stay in fetch_ctrl.

## Test plan
- Reset release, zero-wait memory, if_ready=1 -> addrs 0x0, 0x4, 0x8 issued; if_pc follows; 3-cycle cadence.
- jump=1, jump_target=0x200 during WAIT_RSP, with the stale response 2 cycles later -> stale response discarded, no if_valid for it, next request addr 0x200, flush=1 that single cycle.
- jump and branch_taken both high (targets 0x300/0x400) in FETCH -> next addr 0x300.
- stall=1 for 5 cycles in FETCH -> imem_req_valid=0 throughout; held instruction with if_ready=0 stays stable; request resumes the cycle stall falls.
- pc=64'hFFFF_FFFF_FFFF_FFFC, handoff -> next addr 0x0.
- With the macro: branch_target=0x202 -> addr TRAP_VEC, misalign_exc pulse, exc_addr=0x202. Without the macro: addr 0x200.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg
//   Shared definitions for the instruction-fetch controller: datapath widths
//   and the fetch FSM state encoding.
//   Optional feature macro used by the importing files: PC_MISALIGN_TRAP_EN.
package riscv_fetch_pkg;

    localparam int XLEN       = 64;
    localparam int INSTR_W    = 32;
    localparam int ILEN_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,  // one cycle after reset
        FETCH    = 3'd1,  // request issued while !stall
        WAIT_RSP = 3'd2,  // request accepted, awaiting response
        HOLD     = 3'd3,  // instruction registered and offered to decode
        DRAIN    = 3'd4   // one stale response still to be discarded
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc
//   Combinational next-PC selection: jump target > branch target > pc + 4.
//   Optional feature: PC_MISALIGN_TRAP_EN. When defined, a redirect target
//   with nonzero low bits is replaced by TRAP_VEC and flagged as misaligned;
//   when undefined, redirect targets are forced to instruction alignment.
//
// Ports
//   pc            in   current PC
//   jump          in   unconditional redirect request
//   jump_target   in   jump destination
//   branch_taken  in   taken-branch redirect request
//   branch_target in   branch destination
//   redirect      out  jump | branch_taken
//   next_pc       out  PC to load when redirecting or advancing
//   raw_target    out  selected target before substitution (macro only)
//   misalign      out  selected target is misaligned (macro only)
module fetch_next_pc #(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  TRAP_VEC = 64'h100
) (
    input  logic [XLEN-1:0] pc,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            redirect,
    output logic [XLEN-1:0] next_pc
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic [XLEN-1:0] raw_target,
    output logic            misalign
`endif
);
    import riscv_fetch_pkg::*;

    localparam logic [XLEN-1:0] STEP       = XLEN'(ILEN_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

    logic [XLEN-1:0] target;

    always_comb begin
        target   = jump ? jump_target : branch_target;
        redirect = jump | branch_taken;
`ifdef PC_MISALIGN_TRAP_EN
        raw_target = target;
        misalign   = 1'b0;
        if (redirect) begin
            if ((target & ~ALIGN_MASK) != '0) begin
                next_pc  = TRAP_VEC;
                misalign = 1'b1;
            end else begin
                next_pc = target;
            end
        end else begin
            next_pc = pc + STEP;
        end
`else
        // Low bits of a redirect target are simply cleared.
        if (redirect) begin
            next_pc = target & ALIGN_MASK;
        end else begin
            next_pc = pc + STEP;
        end
`endif
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction-fetch controller. Owns the PC, issues one imem request at a
//   time, applies jump/branch redirects and hazard stalls, and hands each
//   fetched instruction to decode.
//   Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect targets
//   trap to TRAP_VEC; adds misalign_exc and exc_addr ports).
//
// Handshakes: a transfer happens in a cycle where valid & ready are both
//   high at the rising edge. imem_req_valid is not sticky (it follows stall).
//   if_valid/if_pc/if_instr hold steady until if_ready or a redirect.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   stall                         blocks new request issue in FETCH
//   jump, jump_target             execute redirect (highest priority)
//   branch_taken, branch_target   execute taken-branch redirect
//   imem_req_valid/ready/addr     request channel (addr is the PC register)
//   imem_rsp_valid/data           response strobe and instruction word
//   if_valid/ready/pc/instr       decode handoff
//   flush                         combinational jump | branch_taken
//   misalign_exc, exc_addr        misaligned-target trap report (macro only)
module fetch_ctrl #(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h0,
    parameter logic [XLEN-1:0]  TRAP_VEC = 64'h100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            flush
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic            misalign_exc,
    output logic [XLEN-1:0] exc_addr
`endif
);
    import riscv_fetch_pkg::*;

    fetch_state_t        state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic                if_valid_q, if_valid_d;
    logic [XLEN-1:0]     if_pc_q, if_pc_d;
    logic [INSTR_W-1:0]  if_instr_q, if_instr_d;

    logic                redirect;
    logic [XLEN-1:0]     next_pc;
    logic                req_accept;

`ifdef PC_MISALIGN_TRAP_EN
    logic                misalign;
    logic [XLEN-1:0]     raw_target;
    logic                misalign_exc_q, misalign_exc_d;
    logic [XLEN-1:0]     exc_addr_q, exc_addr_d;
`endif

    fetch_next_pc #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_pc (
        .pc            (pc_q),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .redirect      (redirect),
        .next_pc       (next_pc)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .raw_target    (raw_target),
        .misalign      (misalign)
`endif
    );

    assign imem_req_valid = (state_q == FETCH) && !stall;
    assign imem_req_addr  = pc_q;
    assign req_accept     = imem_req_valid && imem_req_ready;

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;
    assign flush    = rst_n & redirect;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        // A redirect wins over every other event; any response seen in the
        // same cycle belongs to the abandoned path and is dropped.
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect) pc_d = next_pc;
            end
            FETCH: begin
                if (redirect) begin
                    pc_d    = next_pc;
                    // An accepted request still owes a response: drain it.
                    state_d = req_accept ? DRAIN : FETCH;
                end else if (req_accept) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (redirect) begin
                    pc_d    = next_pc;
                    state_d = imem_rsp_valid ? FETCH : DRAIN;
                end else if (imem_rsp_valid) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = imem_rsp_data;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (redirect || if_ready) begin
                    // next_pc is the target on redirect, pc + 4 otherwise.
                    pc_d       = next_pc;
                    if_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) pc_d = next_pc;
                if (imem_rsp_valid) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_comb begin
        misalign_exc_d = redirect && misalign;
        exc_addr_d     = (redirect && misalign) ? raw_target : exc_addr_q;
    end

    assign misalign_exc = misalign_exc_q;
    assign exc_addr     = exc_addr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            if_valid_q     <= 1'b0;
            if_pc_q        <= '0;
            if_instr_q     <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_exc_q <= 1'b0;
            exc_addr_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            if_valid_q     <= if_valid_d;
            if_pc_q        <= if_pc_d;
            if_instr_q     <= if_instr_d;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_exc_q <= misalign_exc_d;
            exc_addr_q     <= exc_addr_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
//   Directed bench for fetch_ctrl. Expected request addresses and decode
//   PCs are pushed into queues by the stimulus; a monitor pops and compares
//   them at every request acceptance and decode handoff. A small memory
//   model answers each accepted request after rsp_delay cycles.
//   Honours PC_MISALIGN_TRAP_EN for the misaligned-branch case.
module tb_fetch_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall = 1'b0;
    logic            jump = 1'b0;
    logic [XLEN-1:0] jump_target = '0;
    logic            branch_taken = 1'b0;
    logic [XLEN-1:0] branch_target = '0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b1;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [31:0]     imem_rsp_data = '0;
    logic            if_valid;
    logic            if_ready = 1'b1;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            flush;
`ifdef PC_MISALIGN_TRAP_EN
    logic            misalign_exc;
    logic [XLEN-1:0] exc_addr;
`endif

    fetch_ctrl #(
        .XLEN     (XLEN),
        .RESET_PC (64'h0),
        .TRAP_VEC (64'h100)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .jump           (jump),
        .jump_target    (jump_target),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .flush          (flush)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_exc   (misalign_exc),
        .exc_addr       (exc_addr)
`endif
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int pass_cnt = 0;
    int total_cnt = 0;
    int accept_cnt = 0;
    int hs_cnt = 0;
    int accept_cyc[$];
    logic [XLEN-1:0] exp_addr_q[$];
    logic [XLEN-1:0] exp_pc_q[$];

    function automatic logic [31:0] word_of(input logic [XLEN-1:0] a);
        return a[31:0] ^ 32'h1300_0013;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- memory model ----------------
    int rsp_delay = 1;
    int mem_cnt = 0;
    logic [XLEN-1:0] mem_addr = '0;

    always @(negedge clk) begin
        imem_rsp_valid = 1'b0;
        if (!rst_n) begin
            mem_cnt = 0;
        end else begin
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = word_of(mem_addr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_cnt  = rsp_delay;
                mem_addr = imem_req_addr;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                accept_cyc.push_back(cyc);
                accept_cnt++;
                if (exp_addr_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL req_addr: unexpected request addr %h (cycle %0d)", imem_req_addr, cyc);
                end else begin
                    check("req_addr", imem_req_addr, exp_addr_q.pop_front());
                end
            end
            if (if_valid && if_ready) begin
                hs_cnt++;
                if (exp_pc_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL if_handoff: unexpected instruction pc %h (cycle %0d)", if_pc, cyc);
                end else begin
                    logic [XLEN-1:0] epc;
                    epc = exp_pc_q.pop_front();
                    check("if_pc", if_pc, epc);
                    check("if_instr", {32'h0, if_instr}, {32'h0, word_of(epc)});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_acc(input int target);
        int budget = 200;
        while (accept_cnt < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        if (accept_cnt < target) begin
            total_cnt++;
            $display("FAIL wait_acc: accepts %0d expected %0d before timeout", accept_cnt, target);
        end
    endtask

    task automatic wait_hs(input int target);
        int budget = 200;
        while (hs_cnt < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        if (hs_cnt < target) begin
            total_cnt++;
            $display("FAIL wait_hs: handoffs %0d expected %0d before timeout", hs_cnt, target);
        end
    endtask

    // Release stall, let acc_target requests be accepted, re-stall, then
    // wait for the outstanding instruction to reach decode.
    task automatic run_until(input int acc_target, input int hs_target);
        stall = 1'b0;
        wait_acc(acc_target);
        stall = 1'b1;
        wait_hs(hs_target);
    endtask

    task automatic expect_fetch(input logic [XLEN-1:0] a);
        exp_addr_q.push_back(a);
        exp_pc_q.push_back(a);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state; flush must stay low even with jump asserted.
        jump = 1'b1;
        jump_target = 64'h123;
        repeat (2) @(negedge clk);
        check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("rst_req_addr", imem_req_addr, 64'h0);
        check("rst_if_valid", {63'h0, if_valid}, 64'h0);
        check("rst_if_pc", if_pc, 64'h0);
        check("rst_if_instr", {32'h0, if_instr}, 64'h0);
        check("rst_flush", {63'h0, flush}, 64'h0);
`ifdef PC_MISALIGN_TRAP_EN
        check("rst_misalign_exc", {63'h0, misalign_exc}, 64'h0);
        check("rst_exc_addr", exc_addr, 64'h0);
`endif
        jump = 1'b0;

        // Sequential fetch 0x0, 0x4, 0x8 with zero-wait memory.
        expect_fetch(64'h0);
        expect_fetch(64'h4);
        expect_fetch(64'h8);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_valid", {63'h0, imem_req_valid}, 64'h0);
        @(negedge clk);
        check("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
        wait_acc(3);
        stall = 1'b1;
        wait_hs(3);
        if (accept_cyc.size() >= 3) begin
            check("cadence_0_1", 64'(accept_cyc[1] - accept_cyc[0]), 64'd3);
            check("cadence_1_2", 64'(accept_cyc[2] - accept_cyc[1]), 64'd3);
        end else begin
            total_cnt++;
            $display("FAIL cadence: only %0d accepts recorded, expected 3", accept_cyc.size());
        end

        // Jump during WAIT_RSP; the 0xC response arrives later and is dropped.
        exp_addr_q.push_back(64'hC);
        expect_fetch(64'h200);
        rsp_delay = 2;
        stall = 1'b0;
        wait_acc(4);
        jump = 1'b1;
        jump_target = 64'h200;
        @(negedge clk);
        check("jump_flush", {63'h0, flush}, 64'h1);
        @(posedge clk);
        #1;
        jump = 1'b0;
        rsp_delay = 1;
        @(negedge clk);
        check("jump_flush_clear", {63'h0, flush}, 64'h0);
        wait_acc(5);
        stall = 1'b1;
        wait_hs(4);

        // jump and branch together while stalled in FETCH: jump wins.
        jump = 1'b1;
        jump_target = 64'h300;
        branch_taken = 1'b1;
        branch_target = 64'h400;
        @(negedge clk);
        check("dual_flush", {63'h0, flush}, 64'h1);
        @(posedge clk);
        #1;
        jump = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        check("dual_req_addr", imem_req_addr, 64'h300);
        expect_fetch(64'h300);
        run_until(6, 5);

        // Stall for 5 cycles, then hold an instruction with if_ready low.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
        end
        expect_fetch(64'h304);
        @(posedge clk);
        #1;
        stall = 1'b0;
        if_ready = 1'b0;
        @(negedge clk);
        check("unstall_req_valid", {63'h0, imem_req_valid}, 64'h1);
        @(posedge clk);
        #1 stall = 1'b1;
        begin
            int budget = 20;
            while (!if_valid && budget > 0) begin
                @(negedge clk);
                budget--;
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_if_valid", {63'h0, if_valid}, 64'h1);
            check("hold_if_pc", if_pc, 64'h304);
            check("hold_if_instr", {32'h0, if_instr}, {32'h0, word_of(64'h304)});
        end
        @(posedge clk);
        #1 if_ready = 1'b1;
        wait_hs(6);

        // PC wrap at the top of the address space.
        jump = 1'b1;
        jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
        @(posedge clk);
        #1 jump = 1'b0;
        expect_fetch(64'hFFFF_FFFF_FFFF_FFFC);
        expect_fetch(64'h0);
        run_until(9, 8);

        // Misaligned branch target.
        branch_taken = 1'b1;
        branch_target = 64'h202;
        @(posedge clk);
        #1 branch_taken = 1'b0;
        @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
        check("misalign_req_addr", imem_req_addr, 64'h100);
        check("misalign_exc_pulse", {63'h0, misalign_exc}, 64'h1);
        check("misalign_exc_addr", exc_addr, 64'h202);
        @(negedge clk);
        check("misalign_exc_clear", {63'h0, misalign_exc}, 64'h0);
        expect_fetch(64'h100);
`else
        check("misalign_req_addr", imem_req_addr, 64'h200);
        expect_fetch(64'h200);
`endif
        run_until(10, 9);

        repeat (3) @(posedge clk);
        check("exp_addr_q_empty", 64'(exp_addr_q.size()), 64'h0);
        check("exp_pc_q_empty", 64'(exp_pc_q.size()), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete (%0d/%0d checks passed)", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
